// File: rtl/axi_arb_pkg.sv
// Shared types, constants and the wrap-around search helper for the
// three-channel AXI address arbiter.
package axi_arb_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_WRR   = 2'd2
  } arb_mode_e;

  // First valid channel searching from last_id+1 and wrapping 2 -> 0.
  // last_id itself is the final candidate; with nothing valid, last_id is returned.
  function automatic logic [1:0] next_rr(input logic [2:0] valid, input logic [1:0] last_id);
    logic [1:0] res;
    int         idx;
    res = last_id;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NUM_CH;
      if (valid[idx]) begin
        res = 2'(idx);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational grant selection for the three-channel address arbiter.
// Holds no state: last_id and run_cnt are owned by the top level.
module axi_arb_pick
  import axi_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [NUM_CH-1:0]            valid,
  input  logic [1:0]                   mode,
  input  logic                         en,
  input  logic [1:0]                   last_id,
  input  logic [CNT_W-1:0]             run_cnt,
  input  logic [NUM_CH-1:0][CNT_W-1:0] weights,
  output logic [1:0]                   pick
);

  logic [CNT_W-1:0] weight_s;
  logic [CNT_W-1:0] limit_s;
  logic             last_vld_s;
  logic [1:0]       fixed_s;

  // Weight/valid of the channel that won last, and the fixed-priority candidate.
  always_comb begin
    weight_s   = {CNT_W{1'b0}};
    last_vld_s = 1'b0;
    case (last_id)
      2'd0:    begin weight_s = weights[0]; last_vld_s = valid[0]; end
      2'd1:    begin weight_s = weights[1]; last_vld_s = valid[1]; end
      2'd2:    begin weight_s = weights[2]; last_vld_s = valid[2]; end
      default: begin weight_s = weights[0]; last_vld_s = 1'b0;     end
    endcase
    // A zero weight still allows one grant.
    if (weight_s == {CNT_W{1'b0}}) begin
      limit_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      limit_s = weight_s;
    end
    if (valid[0]) begin
      fixed_s = 2'd0;
    end else if (valid[1]) begin
      fixed_s = 2'd1;
    end else if (valid[2]) begin
      fixed_s = 2'd2;
    end else begin
      fixed_s = 2'd0;
    end
  end

  // Mode-dependent pick; reserved mode 3 falls back to fixed priority.
  always_comb begin
    pick = 2'd0;
    if (!en) begin
      pick = 2'd0;
    end else begin
      case (mode)
        ARB_RR:  pick = next_rr(valid, last_id);
        ARB_WRR: begin
          if (last_vld_s && (run_cnt < limit_s)) begin
            pick = last_id;
          end else begin
            pick = next_rr(valid, last_id);
          end
        end
        default: pick = fixed_s;
      endcase
    end
  end

endmodule

// File: rtl/axi3ch_addr_arb.sv
// Three-channel AXI address arbiter (one instance per AW or AR).
// Zero-latency combinational grant path; a presented request is locked
// until it handshakes. Optional per-channel grant statistics are built
// when the macro ARB_STATS_EN is defined; otherwise grant_cnt* read 0.
module axi3ch_addr_arb
  import axi_arb_pkg::*;
#(
  parameter int PLD_W = 64,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [1:0]                arb_mode,
  input  logic [CNT_W-1:0]          weight0,
  input  logic [CNT_W-1:0]          weight1,
  input  logic [CNT_W-1:0]          weight2,
  input  logic [NUM_CH-1:0]         s_valid,
  input  logic [NUM_CH*PLD_W-1:0]   s_payload,
  output logic [NUM_CH-1:0]         s_ready,
  output logic                      m_valid,
  output logic [PLD_W-1:0]          m_payload,
  output logic [1:0]                m_id,
  input  logic                      m_ready,
  output logic [31:0]               grant_cnt0,
  output logic [31:0]               grant_cnt1,
  output logic [31:0]               grant_cnt2
);

  logic             locked_r;
  logic [1:0]       lock_id_r;
  logic [1:0]       last_id_r;
  logic [CNT_W-1:0] run_cnt_r;
  logic [1:0]       pick_s;
  logic [1:0]       cur_s;
  logic             sel_vld_s;
  logic [PLD_W-1:0] sel_pld_s;
  logic             hs_s;

  axi_arb_pick #(.CNT_W(CNT_W)) u_pick (
    .valid   (s_valid),
    .mode    (arb_mode),
    .en      (arb_en),
    .last_id (last_id_r),
    .run_cnt (run_cnt_r),
    .weights ({weight2, weight1, weight0}),
    .pick    (pick_s)
  );

  // A locked grant overrides the pick. With arb_en=0 the pick is already
  // channel 0, and a locked grant must complete, so every cur is eligible.
  assign cur_s = locked_r ? lock_id_r : pick_s;
  assign hs_s  = m_valid & m_ready;

  // Mux the selected requester downstream; everything reads 0 while in reset.
  always_comb begin
    sel_vld_s = 1'b0;
    sel_pld_s = {PLD_W{1'b0}};
    m_valid   = 1'b0;
    m_payload = {PLD_W{1'b0}};
    m_id      = 2'd0;
    s_ready   = {NUM_CH{1'b0}};
    case (cur_s)
      2'd0:    begin sel_vld_s = s_valid[0]; sel_pld_s = s_payload[0       +: PLD_W]; end
      2'd1:    begin sel_vld_s = s_valid[1]; sel_pld_s = s_payload[PLD_W   +: PLD_W]; end
      2'd2:    begin sel_vld_s = s_valid[2]; sel_pld_s = s_payload[2*PLD_W +: PLD_W]; end
      default: begin sel_vld_s = 1'b0;       sel_pld_s = {PLD_W{1'b0}};             end
    endcase
    if (rst) begin
      m_valid = 1'b0;
    end else begin
      m_valid   = sel_vld_s;
      m_payload = sel_pld_s;
      m_id      = cur_s;
      if (sel_vld_s && m_ready) begin
        s_ready = 3'b001 << cur_s;
      end else begin
        s_ready = {NUM_CH{1'b0}};
      end
    end
  end

  // Lock on a stalled request; track the last winner and its run length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_r  <= 1'b0;
      lock_id_r <= 2'd0;
      last_id_r <= 2'd2;
      run_cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s) begin
      locked_r <= 1'b0;
      if (cur_s == last_id_r) begin
        if (run_cnt_r == {CNT_W{1'b1}}) begin
          run_cnt_r <= run_cnt_r;
        end else begin
          run_cnt_r <= run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        run_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
        last_id_r <= cur_s;
      end
    end else if (m_valid && !m_ready) begin
      locked_r  <= 1'b1;
      lock_id_r <= cur_s;
    end else begin
      locked_r  <= locked_r;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt_r [NUM_CH];

  // Per-channel accepted-transfer counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        grant_cnt_r[k] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (hs_s && (cur_s == 2'(k))) begin
          grant_cnt_r[k] <= grant_cnt_r[k] + 32'd1;
        end else begin
          grant_cnt_r[k] <= grant_cnt_r[k];
        end
      end
    end
  end

  assign grant_cnt0 = grant_cnt_r[0];
  assign grant_cnt1 = grant_cnt_r[1];
  assign grant_cnt2 = grant_cnt_r[2];
`else
  assign grant_cnt0 = 32'd0;
  assign grant_cnt1 = 32'd0;
  assign grant_cnt2 = 32'd0;
`endif

endmodule
